// File: rtl/wishbone_decoder.sv
// Wishbone intercon: one master to NUM_SLAVES slaves by address decode, with a slave
// selection that is held for the whole cycle, a decode-miss error and a bus-timeout watchdog.
module wishbone_decoder #(
  parameter int                            NUM_SLAVES = 4,
  parameter int                            ADR_WIDTH  = 32,
  parameter int                            DAT_WIDTH  = 32,
  parameter int                            TGD_WIDTH  = 1,
  parameter int                            TGC_WIDTH  = 1,
  parameter logic [NUM_SLAVES*ADR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int                            TIMEOUT    = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            m_cyc_i,
  input  logic                            m_stb_i,
  input  logic                            m_we_i,
  input  logic [ADR_WIDTH-1:0]            m_adr_i,
  input  logic [DAT_WIDTH-1:0]            m_dat_i,
  input  logic [DAT_WIDTH/8-1:0]          m_sel_i,
  input  logic [TGC_WIDTH-1:0]            m_tgc_i,
  input  logic [TGD_WIDTH-1:0]            m_tgd_i,
  output logic [DAT_WIDTH-1:0]            m_dat_o,
  output logic [TGD_WIDTH-1:0]            m_tgd_o,
  output logic                            m_ack_o,
  output logic                            m_err_o,
  output logic                            m_rty_o,
  output logic [NUM_SLAVES-1:0]           s_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_stb_o,
  output logic                            s_we_o,
  output logic [ADR_WIDTH-1:0]            s_adr_o,
  output logic [DAT_WIDTH-1:0]            s_dat_o,
  output logic [DAT_WIDTH/8-1:0]          s_sel_o,
  output logic [TGC_WIDTH-1:0]            s_tgc_o,
  output logic [TGD_WIDTH-1:0]            s_tgd_o,
  input  logic [NUM_SLAVES*DAT_WIDTH-1:0] s_dat_i,
  input  logic [NUM_SLAVES*TGD_WIDTH-1:0] s_tgd_i,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_err_i,
  input  logic [NUM_SLAVES-1:0]           s_rty_i
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACTIVE = 3'd1;
  localparam logic [2:0] ST_MISS   = 3'd2;
  localparam logic [2:0] ST_FAULT  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hit_s;
  logic [IDX_W-1:0] hit_idx_s;
  logic             idle_hit_s;
  logic             routed_s;
  logic [IDX_W-1:0] sel_s;
  logic             term_s;
  logic             timeout_s;

  // Address decode; scanning downward makes the lowest matching index win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[i*ADR_WIDTH +: ADR_WIDTH]) == SLAVE_BASE[i*ADR_WIDTH +: ADR_WIDTH]) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Route selection and watchdog expiry for the current cycle.
  always_comb begin
    idle_hit_s = (state_q == ST_IDLE) && m_cyc_i && m_stb_i && hit_s;
    routed_s   = idle_hit_s || (state_q == ST_ACTIVE);
    sel_s      = (state_q == ST_ACTIVE) ? idx_q : hit_idx_s;
    term_s     = routed_s && m_stb_i && (s_ack_i[sel_s] || s_err_i[sel_s] || s_rty_i[sel_s]);
    timeout_s  = (TIMEOUT > 0) && routed_s && m_stb_i && !term_s && (cnt_q == CNT_LAST);
  end

  // Output fabric; everything is forced low while reset is asserted.
  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_tgc_o = '0;
    s_tgd_o = '0;
    m_dat_o = '0;
    m_tgd_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_rty_o = 1'b0;
    if (rst_ni) begin
      s_we_o  = m_we_i;
      s_adr_o = m_adr_i;
      s_dat_o = m_dat_i;
      s_sel_o = m_sel_i;
      s_tgc_o = m_tgc_i;
      s_tgd_o = m_tgd_i;
      if (routed_s) begin
        s_cyc_o[sel_s] = m_cyc_i;
        s_stb_o[sel_s] = m_stb_i;
        m_dat_o        = s_dat_i[sel_s*DAT_WIDTH +: DAT_WIDTH];
        m_tgd_o        = s_tgd_i[sel_s*TGD_WIDTH +: TGD_WIDTH];
        m_ack_o        = s_ack_i[sel_s] & m_stb_i;
        m_err_o        = s_err_i[sel_s] & m_stb_i;
        m_rty_o        = s_rty_i[sel_s] & m_stb_i;
      end else begin
        m_err_o = (state_q == ST_MISS) || (state_q == ST_FAULT);
      end
    end else begin
      m_err_o = 1'b0;
    end
  end

  // Next state: cycle end beats watchdog expiry, and a termination suppresses expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_hit_s) begin
          if (term_s) begin
            state_d = ST_IDLE;
          end else if (timeout_s) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_ACTIVE;
          end
        end else if (m_cyc_i && m_stb_i) begin
          state_d = ST_MISS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_MISS:  state_d = ST_IDLE;
      ST_FAULT: state_d = m_cyc_i ? ST_HOLD : ST_IDLE;
      ST_HOLD:  state_d = m_cyc_i ? ST_HOLD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latched slave index and stall counter.
  always_comb begin
    idx_d = idle_hit_s ? hit_idx_s : idx_q;
    if ((TIMEOUT > 0) && (state_d == ST_ACTIVE) && routed_s && m_stb_i && !term_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = CNT_W'(0);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
